// File: rtl/rlwe_dmem_arb_pkg.sv
// rlwe_dmem_arb_pkg: shared types for the RLWE dmem arbiter slice.
// Holds the memif handshake enums and data vector type, the arbiter state
// encoding, requester ID type and the round-robin pick helper.
`timescale 1ns/1ps

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

package rlwe_dmem_arb_pkg;

    localparam int unsigned SCR1_XLEN = 32;

    typedef logic [SCR1_XLEN-1:0] type_vector;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOCK_M0,
        ARB_LOCK_M1
    } type_rlwe_arb_state_e;

    // Requester ID: 0 = pipeline LSU, 1 = RLWE load/store engine.
    typedef logic type_rlwe_arb_id;

    localparam type_rlwe_arb_id RLWE_ARB_ID_M0 = 1'b0;
    localparam type_rlwe_arb_id RLWE_ARB_ID_M1 = 1'b1;

    localparam int unsigned RLWE_ARB_PERF_CNT_W = 32;

    // Round-robin pick: on a tie the master that was not granted last wins.
    function automatic type_rlwe_arb_id rlwe_arb_rr_pick(
        input logic            m0_req,
        input logic            m1_req,
        input type_rlwe_arb_id rr_last
    );
        if (m0_req && m1_req) begin
            return (rr_last == RLWE_ARB_ID_M1) ? RLWE_ARB_ID_M0 : RLWE_ARB_ID_M1;
        end else if (m1_req) begin
            return RLWE_ARB_ID_M1;
        end else begin
            return RLWE_ARB_ID_M0;
        end
    endfunction

endpackage

// File: rtl/rlwe_arb_id_fifo.sv
// rlwe_arb_id_fifo: in-order FIFO of requester IDs for accepted requests.
// The head entry names the master that owns the next returning response.
// full/empty decode from the registered count only, so a same-cycle pop
// never unblocks a push.
`timescale 1ns/1ps

module rlwe_arb_id_fifo
    import rlwe_dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  type_rlwe_arb_id push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output type_rlwe_arb_id head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // ID storage, written at the tail on every accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (push_en) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rlwe_dmem_arbiter.sv
// rlwe_dmem_arbiter: shares the core dmem port between the pipeline LSU (M0)
// and the RLWE polynomial/NTT load-store engine (M1). Round-robin arbitration
// with the grant locked until the fabric accepts; an ID FIFO steers each
// response back to its requester.
// Optional build macro: RLWE_DMEM_ARB_PERF_EN adds grant/stall counters.
`timescale 1ns/1ps

module rlwe_dmem_arbiter
    import rlwe_dmem_arb_pkg::*;
#(
    parameter int unsigned OUTST_DEPTH = 2,
    parameter int unsigned AW          = `SCR1_DMEM_AWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    // M0: pipeline LSU
    input  logic                 m0_req,
    input  type_scr1_mem_cmd_e   m0_cmd,
    input  type_scr1_mem_width_e m0_width,
    input  logic [AW-1:0]        m0_addr,
    input  type_vector           m0_wdata,
    output logic                 m0_req_ack,
    output type_vector           m0_rdata,
    output type_scr1_mem_resp_e  m0_resp,
    // M1: RLWE load/store engine
    input  logic                 m1_req,
    input  type_scr1_mem_cmd_e   m1_cmd,
    input  type_scr1_mem_width_e m1_width,
    input  logic [AW-1:0]        m1_addr,
    input  type_vector           m1_wdata,
    output logic                 m1_req_ack,
    output type_vector           m1_rdata,
    output type_scr1_mem_resp_e  m1_resp,
    // Downstream dmem fabric
    output logic                 dmem_req,
    output type_scr1_mem_cmd_e   dmem_cmd,
    output type_scr1_mem_width_e dmem_width,
    output logic [AW-1:0]        dmem_addr,
    output type_vector           dmem_wdata,
    input  logic                 dmem_req_ack,
    input  type_vector           dmem_rdata,
    input  type_scr1_mem_resp_e  dmem_resp,
`ifdef RLWE_DMEM_ARB_PERF_EN
    input  logic                           perf_clr,
    output logic [RLWE_ARB_PERF_CNT_W-1:0] perf_m0_grants,
    output logic [RLWE_ARB_PERF_CNT_W-1:0] perf_m1_grants,
    output logic [RLWE_ARB_PERF_CNT_W-1:0] perf_stall_cycles,
`endif
    output logic                 orphan_resp
);

    type_rlwe_arb_state_e state;
    type_rlwe_arb_state_e state_next;
    type_rlwe_arb_id      rr_last;
    type_rlwe_arb_id      sel_id;
    type_rlwe_arb_id      head_id;
    logic                 cand_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 resp_valid;

    rlwe_arb_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) i_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (sel_id),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_id)
    );

    // Arbiter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Last granted master; reset to M1 so M0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= RLWE_ARB_ID_M1;
        end else if (push) begin
            rr_last <= sel_id;
        end
    end

    // Candidate selection, downstream request mux, acks and next state
    always_comb begin
        state_next = state;
        sel_id     = RLWE_ARB_ID_M0;
        cand_req   = 1'b0;
        dmem_cmd   = SCR1_MEM_CMD_RD;
        dmem_width = SCR1_MEM_WIDTH_BYTE;
        dmem_addr  = '0;
        dmem_wdata = '0;

        case (state)
            ARB_LOCK_M0: begin
                sel_id   = RLWE_ARB_ID_M0;
                cand_req = m0_req;
            end
            ARB_LOCK_M1: begin
                sel_id   = RLWE_ARB_ID_M1;
                cand_req = m1_req;
            end
            default: begin
                sel_id   = rlwe_arb_rr_pick(m0_req, m1_req, rr_last);
                cand_req = m0_req | m1_req;
            end
        endcase

        dmem_req = cand_req & ~fifo_full;

        if (dmem_req) begin
            if (sel_id == RLWE_ARB_ID_M1) begin
                dmem_cmd   = m1_cmd;
                dmem_width = m1_width;
                dmem_addr  = m1_addr;
                dmem_wdata = m1_wdata;
            end else begin
                dmem_cmd   = m0_cmd;
                dmem_width = m0_width;
                dmem_addr  = m0_addr;
                dmem_wdata = m0_wdata;
            end
        end

        push       = dmem_req & dmem_req_ack;
        m0_req_ack = push & (sel_id == RLWE_ARB_ID_M0);
        m1_req_ack = push & (sel_id == RLWE_ARB_ID_M1);

        case (state)
            ARB_IDLE: begin
                if (dmem_req && !dmem_req_ack) begin
                    state_next = (sel_id == RLWE_ARB_ID_M1) ? ARB_LOCK_M1 : ARB_LOCK_M0;
                end
            end
            default: begin
                // Accept releases the lock; a dropped request aborts it
                if (push || !cand_req) begin
                    state_next = ARB_IDLE;
                end
            end
        endcase
    end

    // Response routing to the FIFO-head master; empty FIFO means orphan
    always_comb begin
        resp_valid  = (dmem_resp != SCR1_MEM_RESP_NOTRDY);
        pop         = resp_valid & ~fifo_empty;
        orphan_resp = resp_valid & fifo_empty;
        m0_resp     = SCR1_MEM_RESP_NOTRDY;
        m1_resp     = SCR1_MEM_RESP_NOTRDY;
        if (pop) begin
            if (head_id == RLWE_ARB_ID_M1) begin
                m1_resp = dmem_resp;
            end else begin
                m0_resp = dmem_resp;
            end
        end
    end

    assign m0_rdata = dmem_rdata;
    assign m1_rdata = dmem_rdata;

`ifdef RLWE_DMEM_ARB_PERF_EN
    logic stall;

    assign stall = (m0_req | m1_req) & ~(m0_req_ack | m1_req_ack);

    // Saturating grant and stall counters with synchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_m0_grants    <= '0;
            perf_m1_grants    <= '0;
            perf_stall_cycles <= '0;
        end else if (perf_clr) begin
            perf_m0_grants    <= '0;
            perf_m1_grants    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (m0_req_ack && (perf_m0_grants != '1)) begin
                perf_m0_grants <= perf_m0_grants + 1'b1;
            end
            if (m1_req_ack && (perf_m1_grants != '1)) begin
                perf_m1_grants <= perf_m1_grants + 1'b1;
            end
            if (stall && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rlwe_dmem_arbiter.sv
// tb_rlwe_dmem_arbiter: directed bench for rlwe_dmem_arbiter with a
// queue-based model checked every cycle plus literal expectations per scenario.
`timescale 1ns/1ps

module tb_rlwe_dmem_arbiter;
    import rlwe_dmem_arb_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 m0_req, m1_req;
    type_scr1_mem_cmd_e   m0_cmd, m1_cmd;
    type_scr1_mem_width_e m0_width, m1_width;
    logic [31:0]          m0_addr, m1_addr;
    type_vector           m0_wdata, m1_wdata;
    logic                 m0_req_ack, m1_req_ack;
    type_vector           m0_rdata, m1_rdata;
    type_scr1_mem_resp_e  m0_resp, m1_resp;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr;
    type_vector           dmem_wdata;
    logic                 dmem_req_ack;
    type_vector           dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;
    logic                 orphan_resp;
`ifdef RLWE_DMEM_ARB_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_m0_grants, perf_m1_grants, perf_stall_cycles;
`endif

    rlwe_dmem_arbiter #(
        .OUTST_DEPTH (DEPTH),
        .AW          (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_cmd       (m0_cmd),
        .m0_width     (m0_width),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_req_ack   (m0_req_ack),
        .m0_rdata     (m0_rdata),
        .m0_resp      (m0_resp),
        .m1_req       (m1_req),
        .m1_cmd       (m1_cmd),
        .m1_width     (m1_width),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_req_ack   (m1_req_ack),
        .m1_rdata     (m1_rdata),
        .m1_resp      (m1_resp),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
`ifdef RLWE_DMEM_ARB_PERF_EN
        .perf_clr          (perf_clr),
        .perf_m0_grants    (perf_m0_grants),
        .perf_m1_grants    (perf_m1_grants),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .orphan_resp  (orphan_resp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of outstanding owner IDs, current lock owner, last winner
    int q[$];
    int lock_owner = -1;
    int last_win   = 1;
    int m_g0 = 0, m_g1 = 0, m_st = 0;

    always @(negedge clk) begin : model
        int          who;
        int          hd;
        bit          act, full, dreq, acc, rv;
        logic [31:0] e_addr, e_wdata;
        logic        e_cmd;
        logic [1:0]  e_width;
`ifdef RLWE_DMEM_ARB_PERF_EN
        chk("perf_m0", perf_m0_grants, m_g0);
        chk("perf_m1", perf_m1_grants, m_g1);
        chk("perf_stall", perf_stall_cycles, m_st);
`endif
        if (rst) begin
            q.delete();
            lock_owner = -1;
            last_win   = 1;
            m_g0 = 0; m_g1 = 0; m_st = 0;
            chk("rst_m0_ack", m0_req_ack, 0);
            chk("rst_m1_ack", m1_req_ack, 0);
            chk("rst_dreq", dmem_req, 0);
            chk("rst_daddr", dmem_addr, 0);
            chk("rst_dwdata", dmem_wdata, 0);
            chk("rst_dcmd", dmem_cmd, 0);
            chk("rst_dwidth", dmem_width, 0);
            chk("rst_m0_resp", m0_resp, SCR1_MEM_RESP_NOTRDY);
            chk("rst_m1_resp", m1_resp, SCR1_MEM_RESP_NOTRDY);
            chk("rst_orphan", orphan_resp, dmem_resp != SCR1_MEM_RESP_NOTRDY);
        end else begin
            if (lock_owner >= 0) begin
                who = lock_owner;
                act = (lock_owner == 0) ? m0_req : m1_req;
            end else if (m0_req && m1_req) begin
                who = 1 - last_win;
                act = 1'b1;
            end else begin
                who = m1_req ? 1 : 0;
                act = m0_req || m1_req;
            end
            full = (q.size() >= DEPTH);
            dreq = act && !full;
            acc  = dreq && dmem_req_ack;
            e_addr  = !dreq ? 32'h0 : (who == 0 ? m0_addr : m1_addr);
            e_wdata = !dreq ? 32'h0 : (who == 0 ? m0_wdata : m1_wdata);
            e_cmd   = !dreq ? 1'b0 : (who == 0 ? m0_cmd : m1_cmd);
            e_width = !dreq ? 2'b00 : (who == 0 ? m0_width : m1_width);
            rv = (dmem_resp != SCR1_MEM_RESP_NOTRDY);
            hd = (rv && q.size() > 0) ? q[0] : -1;

            chk("dmem_req", dmem_req, dreq);
            chk("dmem_addr", dmem_addr, e_addr);
            chk("dmem_wdata", dmem_wdata, e_wdata);
            chk("dmem_cmd", dmem_cmd, e_cmd);
            chk("dmem_width", dmem_width, e_width);
            chk("m0_req_ack", m0_req_ack, acc && who == 0);
            chk("m1_req_ack", m1_req_ack, acc && who == 1);
            chk("m0_resp", m0_resp, (hd == 0) ? dmem_resp : SCR1_MEM_RESP_NOTRDY);
            chk("m1_resp", m1_resp, (hd == 1) ? dmem_resp : SCR1_MEM_RESP_NOTRDY);
            chk("orphan", orphan_resp, rv && q.size() == 0);
            chk("m0_rdata", m0_rdata, dmem_rdata);
            chk("m1_rdata", m1_rdata, dmem_rdata);

`ifdef RLWE_DMEM_ARB_PERF_EN
            if (perf_clr) begin
                m_g0 = 0; m_g1 = 0; m_st = 0;
            end else begin
                if (acc && who == 0) m_g0++;
                if (acc && who == 1) m_g1++;
                if ((m0_req || m1_req) && !acc) m_st++;
            end
`endif
            if (hd >= 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(who);
                last_win   = who;
                lock_owner = -1;
            end else if (dreq) begin
                lock_owner = who;
            end else begin
                lock_owner = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req       = 1'b0;
        m1_req       = 1'b0;
        dmem_req_ack = 1'b0;
        dmem_resp    = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata   = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        m0_cmd   = SCR1_MEM_CMD_RD;
        m1_cmd   = SCR1_MEM_CMD_RD;
        m0_width = SCR1_MEM_WIDTH_WORD;
        m1_width = SCR1_MEM_WIDTH_WORD;
        m0_addr  = '0;
        m1_addr  = '0;
        m0_wdata = '0;
        m1_wdata = '0;
        idle_inputs();
`ifdef RLWE_DMEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single master read, same-cycle ack, response two cycles later
        m0_req = 1'b1; m0_addr = 32'h100; dmem_req_ack = 1'b1;
        #2;
        chk("t1_m0_ack", m0_req_ack, 1);
        chk("t1_daddr", dmem_addr, 32'h100);
        tick();
        idle_inputs();
        tick();
        dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'hA5;
        #2;
        chk("t1_m0_resp", m0_resp, SCR1_MEM_RESP_RDY_OK);
        chk("t1_m0_rdata", m0_rdata, 32'hA5);
        chk("t1_m1_resp", m1_resp, SCR1_MEM_RESP_NOTRDY);
        tick();
        idle_inputs();
        pulse_reset();

        // Contention: alternating grants, responses follow grant order
        m0_addr = 32'h200;
        m1_addr = 32'h300; m1_cmd = SCR1_MEM_CMD_WR;
        m1_wdata = 32'hDEADBEEF; m1_width = SCR1_MEM_WIDTH_HWORD;
        for (int k = 0; k <= 4; k++) begin
            m0_req = (k < 4); m1_req = (k < 4); dmem_req_ack = (k < 4);
            if (k >= 1) begin
                dmem_resp  = SCR1_MEM_RESP_RDY_OK;
                dmem_rdata = 32'h10 + k;
            end
            #2;
            if (k < 4) begin
                chk("t2_m0_ack", m0_req_ack, (k % 2) == 0);
                chk("t2_m1_ack", m1_req_ack, (k % 2) == 1);
            end
            if (k >= 1) begin
                chk("t2_m0_resp", m0_resp, ((k - 1) % 2 == 0) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY);
                chk("t2_m1_resp", m1_resp, ((k - 1) % 2 == 1) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY);
            end
            tick();
        end
        idle_inputs();
        tick();

        // Lock: M1 holds the grant through three ack-less cycles with M0 pending
        for (int k = 0; k < 6; k++) begin
            m1_req = (k < 5);
            m0_req = (k >= 1);
            dmem_req_ack = (k >= 4);
            #2;
            if (k < 5) chk("t3_daddr_m1", dmem_addr, 32'h300);
            if (k < 4) chk("t3_m0_ack_low", m0_req_ack, 0);
            if (k == 4) chk("t3_m1_ack", m1_req_ack, 1);
            if (k == 5) begin
                chk("t3_m0_ack", m0_req_ack, 1);
                chk("t3_daddr_m0", dmem_addr, 32'h200);
            end
            tick();
        end
        idle_inputs();
        dmem_resp = SCR1_MEM_RESP_RDY_OK;
        #2;
        chk("t3_m1_resp", m1_resp, SCR1_MEM_RESP_RDY_OK);
        tick();
        dmem_resp = SCR1_MEM_RESP_RDY_ER;
        #2;
        chk("t3_m0_resp", m0_resp, SCR1_MEM_RESP_RDY_ER);
        tick();
        idle_inputs();
        tick();

        // Full: two outstanding block a third request until a response returns
        m0_addr = 32'h400;
        for (int k = 0; k < 8; k++) begin
            m0_req = (k < 6);
            dmem_req_ack = (k < 2) || (k == 5);
            dmem_resp = (k == 4 || k == 6 || k == 7) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
            #2;
            if (k == 2 || k == 3 || k == 4) chk("t4_dreq_blocked", dmem_req, 0);
            if (k == 5) chk("t4_dreq_resumed", dmem_req, 1);
            tick();
        end
        idle_inputs();
        tick();

        // Orphan: response outstanding across a reset is dropped
        m0_req = 1'b1; dmem_req_ack = 1'b1;
        tick();
        idle_inputs();
        pulse_reset();
        dmem_resp = SCR1_MEM_RESP_RDY_OK;
        #2;
        chk("t5_orphan", orphan_resp, 1);
        chk("t5_m0_resp", m0_resp, SCR1_MEM_RESP_NOTRDY);
        chk("t5_m1_resp", m1_resp, SCR1_MEM_RESP_NOTRDY);
        tick();
        idle_inputs();
        #2;
        chk("t5_orphan_end", orphan_resp, 0);
        tick();

`ifdef RLWE_DMEM_ARB_PERF_EN
        // Counters: 3 M0 grants, 2 M1 grants, 4 stalls, then clear
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        #2;
        chk("p_clr_m0", perf_m0_grants, 0);
        tick();
        for (int k = 0; k <= 10; k++) begin
            m0_req = (k <= 8);
            m1_req = (k <= 7);
            dmem_req_ack = (k == 0 || k == 3 || k == 4 || k == 7 || k == 8);
            dmem_resp = (k >= 1) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
            if (k == 9) begin
                #2;
                chk("p_m0", perf_m0_grants, 3);
                chk("p_m1", perf_m1_grants, 2);
                chk("p_stall", perf_stall_cycles, 4);
            end
            if (k == 10) perf_clr = 1'b1;
            tick();
        end
        perf_clr = 1'b0;
        idle_inputs();
        #2;
        chk("p_clr2_m0", perf_m0_grants, 0);
        chk("p_clr2_m1", perf_m1_grants, 0);
        chk("p_clr2_st", perf_stall_cycles, 0);
        tick();
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rlwe_dmem_arbiter.md
Name: rlwe_dmem_arbiter

Overview:
- Shares the single core data-memory port between two requesters:
  - M0: pipeline LSU.
  - M1: RLWE polynomial/NTT load-store engine.
- Sits between the core top-level and the dmem fabric, using the same req/req_ack/resp memif handshake.
- Arbitration is round-robin with a grant lock held until the request is accepted.
- A small in-order ID FIFO routes each response back to the requester that issued it.

Parameters:
- OUTST_DEPTH, 2, max accepted-but-unanswered requests; power of 2, >=1.
- AW, `SCR1_DMEM_AWIDTH, dmem address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- m0_req / m1_req  in  1  request.
- m0_cmd / m1_cmd  in  type_scr1_mem_cmd_e  read/write.
- m0_width / m1_width  in  type_scr1_mem_width_e  access width.
- m0_addr / m1_addr  in  AW  address.
- m0_wdata / m1_wdata  in  type_vector  write data.
- m0_req_ack / m1_req_ack  out  1  request accepted.
- m0_rdata / m1_rdata  out  type_vector  read data.
- m0_resp / m1_resp  out  type_scr1_mem_resp_e  response.
- dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata  out  as above  downstream request.
- dmem_req_ack  in  1;  dmem_rdata  in  type_vector;  dmem_resp  in  type_scr1_mem_resp_e.
- orphan_resp  out  1  pulse: response arrived with empty ID FIFO.

Behaviour:
- Reset values:
  - All req_ack and dmem_req = 0.
  - resp outputs = SCR1_MEM_RESP_NOTRDY.
  - dmem_cmd/width/addr/wdata = 0.
  - ID FIFO empty; state ARB_IDLE; rr_last = M1, so M0 wins the first tie.
  - orphan_resp = 0.
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- FSM states and transitions:
  - ARB_IDLE:
    - Candidate = the requesting master; if both request, the master != rr_last.
    - If a candidate exists and fifo_full=0: drive dmem_* from the candidate combinationally (zero-cycle latency).
    - If dmem_req_ack=1 the same cycle: push the candidate ID, set rr_last, stay in ARB_IDLE.
    - Otherwise go to ARB_LOCK_Mx.
  - ARB_LOCK_Mx:
    - Keep selecting Mx regardless of the other master's request.
    - On dmem_req_ack: push ID, set rr_last=x, go to ARB_IDLE.
    - If mx_req drops before ack (protocol abort): go to ARB_IDLE, no push, rr_last unchanged.
- Gating:
  - dmem_req = candidate_req & ~fifo_full. fifo_full is decoded from the registered count.
  - A pop in the same cycle does not unblock a push; full holds for that cycle.
  - mx_req_ack = dmem_req_ack & dmem_req & (selected==x).
- Response routing:
  - When dmem_resp != NOTRDY and the FIFO is non-empty: the FIFO-head master gets dmem_resp; the other master sees NOTRDY; pop.
  - dmem_rdata is broadcast to both mx_rdata, with no registering.
- Simultaneous push+pop on a non-full FIFO: count unchanged, both pointers advance. Pointers wrap modulo OUTST_DEPTH.
- Response with FIFO empty (e.g. stale response after reset): dropped; orphan_resp=1 for that cycle.
- Reset mid-transaction: FIFO, FSM and rr_last cleared immediately (async). Outstanding fabric responses become orphans.

Optional Feature:
- Macro: RLWE_DMEM_ARB_PERF_EN.
- Defined, adds three 32-bit saturating counters:
  - outputs perf_m0_grants and perf_m1_grants: increment on mx_req_ack.
  - output perf_stall_cycles: increments each cycle with any mx_req high and no req_ack.
  - input perf_clr (sync): zeroes all three.
  - All counters reset to 0.
- Undefined: these ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package rlwe_dmem_arb_pkg holds:
  - typedef enum type_rlwe_arb_state_e {ARB_IDLE, ARB_LOCK_M0, ARB_LOCK_M1}.
  - typedef logic type_rlwe_arb_id (0=M0, 1=M1).
  - localparam RLWE_ARB_PERF_CNT_W=32.
- Memif enums and type_vector come from the existing shared headers.
- One sub-module: rlwe_arb_id_fifo (depth OUTST_DEPTH, 1-bit entries, push/pop/full/empty/head).

Test Plan:
- Single master: M0 read addr 0x100, ack same cycle; 2 cycles later resp RDY_OK, rdata=0xA5 → m0_req_ack=1 in the request cycle; m0_resp=RDY_OK, m0_rdata=0xA5; m1_resp stays NOTRDY.
- Contention: both masters request continuously for 4 accepts, fabric acks every cycle, fast responses → grant order M0,M1,M0,M1; responses routed in the same order.
- Lock: M1 granted, dmem_req_ack held 0 for 3 cycles while M0 requests → dmem_addr stays M1's for all 3 cycles; M0 is granted the cycle after M1's ack.
- Full: OUTST_DEPTH=2, two reads accepted with responses withheld → dmem_req=0 despite pending m0_req; first response returns → dmem_req reasserts the next cycle.
- Orphan/reset: one read accepted, rst pulsed, then RDY_OK arrives → no mx_resp asserted; orphan_resp=1 for exactly 1 cycle.
- RLWE_DMEM_ARB_PERF_EN: 3 M0 grants, 2 M1 grants, 4 stall cycles → counters read 3/2/4; perf_clr → all 0 the next cycle.
